// File: rtl/mem_dma.sv
// Bus-master byte copy engine for the 512-byte program memory (RD/CAP/WR per byte).
// Optional fill mode (pattern to N destination bytes) is built when MEM_DMA_FILL_EN is defined.
module mem_dma #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic              fill,
  input  logic [7:0]        pattern,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_ab,
  output logic              mem_we,
  output logic              mem_cs,
  output logic              mem_cs_o,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] src_p, dst_p, ab_q;
  logic [LEN_W-1:0]  cnt;
  logic [7:0]        data_q;
  logic              start_fill, fill_mode;

`ifdef MEM_DMA_FILL_EN
  logic       fill_q;
  logic [7:0] pat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= 1'b0;
      pat_q  <= 8'h00;
    end else if (state == IDLE && start) begin
      fill_q <= fill;
      pat_q  <= pattern;
    end
  end

  assign start_fill = fill;
  assign fill_mode  = fill_q;
  assign mem_wdata  = fill_q ? pat_q : data_q;
`else
  logic unused_fill;
  assign unused_fill = ^{fill, pattern};
  assign start_fill  = 1'b0;
  assign fill_mode   = 1'b0;
  assign mem_wdata   = data_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      src_p  <= '0;
      dst_p  <= '0;
      cnt    <= '0;
      data_q <= 8'h00;
      ab_q   <= '0;
    end else begin
      state <= state_nx;
      ab_q  <= mem_ab;  // lets the bus address hold while idle
      case (state)
        IDLE: if (start) begin
          src_p <= src;
          dst_p <= dst;
          cnt   <= len;
        end
        CAP: data_q <= mem_rdata;
        WR: begin
          src_p <= src_p + ADDR_W'(1);
          dst_p <= dst_p + ADDR_W'(1);
          cnt   <= cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    mem_ab   = ab_q;
    mem_we   = 1'b0;
    mem_cs_o = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (len == '0)      state_nx = FIN;
        else if (start_fill) state_nx = WR;
        else                state_nx = RD;
      end
      RD: begin
        mem_ab   = src_p;
        mem_cs_o = 1'b1;
        state_nx = CAP;
      end
      CAP: begin
        mem_ab   = src_p;
        mem_cs_o = 1'b1;
        state_nx = WR;
      end
      WR: begin
        mem_ab = dst_p;
        mem_we = 1'b1;
        if (cnt == LEN_W'(1)) state_nx = FIN;
        else                  state_nx = fill_mode ? WR : RD;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The target writes whenever CS is low, so CS stays asserted permanently.
  assign mem_cs = 1'b1;
  assign busy   = (state == RD) || (state == CAP) || (state == WR);
  assign done   = (state == FIN);

endmodule

// File: tb/tb_mem_dma.sv
// Directed vector bench for mem_dma with a behavioural model of the 512-byte memory target.
module tb_mem_dma;

  logic       clk = 1'b0;
  logic       reset, start, fill;
  logic [8:0] src, dst;
  logic [9:0] len;
  logic [7:0] pattern;
  logic       busy, done, mem_we, mem_cs, mem_cs_o;
  logic [8:0] mem_ab;
  logic [7:0] mem_wdata, mem_rdata;

  mem_dma dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .fill(fill), .pattern(pattern), .busy(busy), .done(done), .mem_ab(mem_ab),
    .mem_we(mem_we), .mem_cs(mem_cs), .mem_cs_o(mem_cs_o), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] img [13] = '{8'hA9, 8'h00, 8'h8D, 8'h00, 8'h02, 8'hA2, 8'h05,
                           8'hE8, 8'hCA, 8'hD0, 8'hFD, 8'hEA, 8'hAA};

  function automatic logic [7:0] base(input int i);
    if (i < 13) return img[i];
    return 8'((i * 37 + 5) & 255);
  endfunction

  // memory target: writes when NOT(CS & ~WE), registered read
  logic [7:0] mem [512];
  logic       load = 1'b0;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 512; i++) mem[i] <= base(i);
    end else if (!(mem_cs && !mem_we)) begin
      mem[mem_ab] <= mem_wdata;
    end
    mem_rdata <= mem[mem_ab];
  end

  typedef struct {
    string      name;
    logic [8:0] src, dst;
    logic [9:0] len;
    logic       fill;
    logic [7:0] pat;
    logic       poke;
    int         exp_lat;
    int         exp_wr;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] refm [512];
  int         checks = 0, fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    for (int i = 0; i < 512; i++) refm[i] = base(i);
  endtask

  task automatic chk_mem(input string nm);
    int bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (mem[i] !== refm[i]) begin
        if (bad == 0) $display("FAIL %s: mem[%0h]=%0h, expected %0h", nm, i, mem[i], refm[i]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) fails++;
  endtask

  task automatic run(input vec_t v);
    int         lat = 0, wr = 0, csl = 0, berr = 0, rerr = 0, nrd = 0;
    bit         got = 0, eff_fill = 0;
    logic       prev_o = 1'b0;
    logic [8:0] a, b;
`ifdef MEM_DMA_FILL_EN
    eff_fill = v.fill;
`endif
    load_mem();
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.src + 9'(i);
      b = v.dst + 9'(i);
      refm[b] = eff_fill ? v.pat : refm[a];
    end
    @(negedge clk);
    src = v.src; dst = v.dst; len = v.len; fill = v.fill; pattern = v.pat; start = 1'b1;
    while (!got && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (v.poke && lat == 5) begin
        dst = v.dst + 9'h080; len = 10'd3; start = 1'b1;
      end
      if (v.poke && lat == 6) start = 1'b0;
      if (!mem_cs) csl++;
      if (mem_we) wr++;
      if (mem_cs_o && !prev_o) begin
        a = v.src + 9'(nrd);
        if (mem_ab !== a) rerr++;
        nrd++;
      end
      prev_o = mem_cs_o;
      if (done) begin
        got = 1;
        if (busy) berr++;
      end else if (!busy) berr++;
    end
    chk({v.name, " done latency"}, lat, v.exp_lat);
    chk({v.name, " write cycles"}, wr, v.exp_wr);
    chk({v.name, " cs low cycles"}, csl, 0);
    chk({v.name, " busy errors"}, berr, 0);
    if (!eff_fill) begin
      chk({v.name, " read count"}, nrd, int'(v.len));
      chk({v.name, " read order errors"}, rerr, 0);
    end
    @(negedge clk);
    chk({v.name, " done/busy after done"}, int'({done, busy}), 0);
    chk_mem({v.name, " memory"});
  endtask

  localparam logic [21:0] RST_OUT = {1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 8'd0};

  initial begin
    int wr, lat;
    reset = 1'b1; start = 1'b0; fill = 1'b0; src = '0; dst = '0; len = '0; pattern = '0;
    vecs[0] = '{"copy13", 9'h000, 9'h100, 10'd13, 1'b0, 8'h00, 1'b0, 40, 13};
    vecs[1] = '{"src_wrap", 9'h1FE, 9'h0F0, 10'd4, 1'b0, 8'h00, 1'b0, 13, 4};
    vecs[2] = '{"len0", 9'h010, 9'h020, 10'd0, 1'b0, 8'h00, 1'b0, 1, 0};
    vecs[3] = '{"overlap", 9'h000, 9'h002, 10'd6, 1'b0, 8'h00, 1'b0, 19, 6};
    vecs[4] = '{"dst_wrap", 9'h010, 9'h1FD, 10'd5, 1'b0, 8'h00, 1'b0, 16, 5};
    vecs[5] = '{"len1", 9'h1FF, 9'h000, 10'd1, 1'b0, 8'h00, 1'b0, 4, 1};
    vecs[6] = '{"restart_ignored", 9'h000, 9'h100, 10'd8, 1'b0, 8'h00, 1'b1, 25, 8};
`ifdef MEM_DMA_FILL_EN
    vecs[7] = '{"fill16", 9'h000, 9'h020, 10'd16, 1'b1, 8'hEA, 1'b0, 17, 16};
`else
    vecs[7] = '{"fill16", 9'h000, 9'h020, 10'd16, 1'b1, 8'hEA, 1'b0, 49, 16};
`endif
    vecs[8] = '{"full512", 9'h000, 9'h100, 10'd512, 1'b0, 8'h00, 1'b0, 1537, 512};

    repeat (3) @(negedge clk);
    chk("reset outputs", int'({busy, done, mem_ab, mem_we, mem_cs, mem_cs_o, mem_wdata}), int'(RST_OUT));
    reset = 1'b0;

    foreach (vecs[k]) run(vecs[k]);

    // reset during the 5th WR of a len=10 copy: the write at that edge still lands
    load_mem();
    for (int i = 0; i < 5; i++) refm[9'h140 + 9'(i)] = base(i);
    @(negedge clk);
    src = 9'h000; dst = 9'h140; len = 10'd10; fill = 1'b0; start = 1'b1;
    wr = 0; lat = 0;
    while (lat < 15) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (mem_we) wr++;
    end
    chk("reset test 5th write cycle", int'({mem_we, mem_ab}), int'({1'b1, 9'h144}));
    chk("reset test writes before reset", wr, 5);
    reset = 1'b1;
    @(negedge clk);
    chk("outputs after mid-copy reset", int'({busy, done, mem_ab, mem_we, mem_cs, mem_cs_o, mem_wdata}), int'(RST_OUT));
    reset = 1'b0;
    wr = 0;
    repeat (30) begin
      @(negedge clk);
      if (mem_we || busy || done) wr++;
    end
    chk("activity after reset", wr, 0);
    chk_mem("reset test memory");

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
